// File: rtl/life_pkg.sv
// Shared types for the Game of Life cursor/edit controller.
// Edit modes, direction bit indices and key-repeat states.
package life_pkg;

    typedef enum logic [1:0] {
        MODE_MOVE   = 2'b00,
        MODE_PAINT  = 2'b01,
        MODE_ERASE  = 2'b10,
        MODE_TOGGLE = 2'b11
    } edit_mode_e;

    localparam int DIR_XM = 3;
    localparam int DIR_YP = 2;
    localparam int DIR_YM = 1;
    localparam int DIR_XP = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DELAY  = 2'b01,
        REPEAT = 2'b10
    } repeat_state_e;

endpackage

// File: rtl/life_key_repeat.sv
// Hold-to-repeat for one direction button.
// Emits a one-cycle step on press, after a delay, then at a fixed rate.
module life_key_repeat
    import life_pkg::*;
#(
    parameter int REPEAT_DELAY = 16,
    parameter int REPEAT_RATE  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic key,
    output logic step
);

    localparam int MAXC = (REPEAT_DELAY > REPEAT_RATE) ?
                          REPEAT_DELAY : REPEAT_RATE;
    localparam int CW = $clog2(MAXC);
    localparam logic [CW-1:0] DLY_END = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RPT_END = CW'(REPEAT_RATE - 1);

    repeat_state_e state_q;
    repeat_state_e state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          step_d;

    // next state, counter and step decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = 1'b0;
        if (clr) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (key) begin
                        step_d  = 1'b1;
                        state_d = DELAY;
                        cnt_d   = '0;
                    end
                end
                DELAY: begin
                    if (!key) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == DLY_END) begin
                        step_d  = 1'b1;
                        state_d = REPEAT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!key) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == RPT_END) begin
                        step_d = 1'b1;
                        cnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // state, counter and registered step
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            step    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step    <= step_d;
        end
    end

endmodule

// File: rtl/life_cursor_ctrl.sv
// Cursor and cell-edit controller for the Game of Life board.
// Turns repeated button steps into moves, edits and a blinking cursor.
module life_cursor_ctrl
    import life_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int HEIGHT       = 8,
    parameter int WRAP         = 1,
    parameter int REPEAT_DELAY = 16,
    parameter int REPEAT_RATE  = 4,
    parameter int BLINK_PERIOD = 8,
    localparam int XW = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1,
    localparam int YW = ($clog2(HEIGHT) > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic [3:0]    dir,
    input  logic [1:0]    mode,
    input  logic          action,
    input  logic          cell_rd,
    output logic [XW-1:0] cur_x,
    output logic [YW-1:0] cur_y,
    output logic          cursor_vis,
    output logic          cell_we,
    output logic [XW-1:0] cell_x,
    output logic [YW-1:0] cell_y,
    output logic          cell_wdata
);

    localparam int BW = (BLINK_PERIOD > 2) ? $clog2(BLINK_PERIOD) : 1;
    localparam logic [BW-1:0] BLINK_END =
        BW'((BLINK_PERIOD > 0) ? BLINK_PERIOD - 1 : 0);
    localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);
    localparam logic [XW-1:0] X_MID = XW'(WIDTH / 2);
    localparam logic [YW-1:0] Y_MID = YW'(HEIGHT / 2);

    logic [3:0]    step;
    logic          clr;
    edit_mode_e    md;
    logic [XW-1:0] nx;
    logic [YW-1:0] ny;
    logic          moved;
    logic          act_q;
    logic          act_edge;
    logic          en_q;
    logic          we_d;
    logic [XW-1:0] wx_d;
    logic [YW-1:0] wy_d;
    logic          wd_d;
    logic [BW-1:0] bcnt_q;
    logic [BW-1:0] bcnt_d;
    logic          vis_d;

    assign clr      = ~enable;
    assign md       = edit_mode_e'(mode);
    assign act_edge = action & ~act_q;

    for (genvar g = 0; g < 4; g++) begin : g_key
        life_key_repeat #(
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE)
        ) u_key (
            .clk  (clk),
            .reset(reset),
            .clr  (clr),
            .key  (dir[g]),
            .step (step[g])
        );
    end

    // destination cell; a blocked clamp move counts as no move
    always_comb begin
        nx    = cur_x;
        ny    = cur_y;
        moved = 1'b0;
        if (enable && $onehot(step)) begin
            moved = 1'b1;
            unique case (1'b1)
                step[DIR_XM]: begin
                    if (cur_x != '0)      nx = cur_x - 1'b1;
                    else if (WRAP != 0)   nx = X_MAX;
                    else                  moved = 1'b0;
                end
                step[DIR_XP]: begin
                    if (cur_x != X_MAX)   nx = cur_x + 1'b1;
                    else if (WRAP != 0)   nx = '0;
                    else                  moved = 1'b0;
                end
                step[DIR_YM]: begin
                    if (cur_y != '0)      ny = cur_y - 1'b1;
                    else if (WRAP != 0)   ny = Y_MAX;
                    else                  moved = 1'b0;
                end
                step[DIR_YP]: begin
                    if (cur_y != Y_MAX)   ny = cur_y + 1'b1;
                    else if (WRAP != 0)   ny = '0;
                    else                  moved = 1'b0;
                end
                default: moved = 1'b0;
            endcase
        end
    end

    // write request: a move wins over an action edge
    always_comb begin
        we_d = 1'b0;
        wx_d = cell_x;
        wy_d = cell_y;
        wd_d = cell_wdata;
        if (moved) begin
            if (md == MODE_PAINT || md == MODE_ERASE) begin
                we_d = 1'b1;
                wx_d = nx;
                wy_d = ny;
                wd_d = (md == MODE_PAINT);
            end
        end else if (enable && act_edge && md != MODE_MOVE) begin
            we_d = 1'b1;
            wx_d = cur_x;
            wy_d = cur_y;
            unique case (md)
                MODE_PAINT:  wd_d = 1'b1;
                MODE_ERASE:  wd_d = 1'b0;
                MODE_TOGGLE: wd_d = ~cell_rd;
                default:     wd_d = cell_wdata;
            endcase
        end
    end

    // cursor blink: restart solid on enable rise or move
    always_comb begin
        vis_d  = cursor_vis;
        bcnt_d = bcnt_q;
        if (!enable) begin
            vis_d  = 1'b0;
            bcnt_d = '0;
        end else if (BLINK_PERIOD == 0) begin
            vis_d  = 1'b1;
            bcnt_d = '0;
        end else if (!en_q || moved) begin
            vis_d  = 1'b1;
            bcnt_d = '0;
        end else if (bcnt_q == BLINK_END) begin
            vis_d  = ~cursor_vis;
            bcnt_d = '0;
        end else begin
            bcnt_d = bcnt_q + 1'b1;
        end
    end

    // cursor, write port, blink and history registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_x      <= X_MID;
            cur_y      <= Y_MID;
            cursor_vis <= 1'b0;
            cell_we    <= 1'b0;
            cell_x     <= '0;
            cell_y     <= '0;
            cell_wdata <= 1'b0;
            bcnt_q     <= '0;
            act_q      <= 1'b0;
            en_q       <= 1'b0;
        end else begin
            cur_x      <= nx;
            cur_y      <= ny;
            cursor_vis <= vis_d;
            cell_we    <= we_d;
            cell_x     <= wx_d;
            cell_y     <= wy_d;
            cell_wdata <= wd_d;
            bcnt_q     <= bcnt_d;
            act_q      <= action;
            en_q       <= enable;
        end
    end

endmodule

// File: tb/tb_life_cursor_ctrl.sv
// Bench for life_cursor_ctrl: directed tables plus random stimulus.
// Two instances (wrap and clamp) share inputs and a reference model.
module tb_life_cursor_ctrl;

    localparam int W = 20;
    localparam int H = 20;
    localparam int RD = 4;
    localparam int RR = 2;
    localparam int BP = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] dir;
    logic [1:0] mode;
    logic       action;
    logic       cell_rd;

    logic [4:0] x0, wx0, x1, wx1;
    logic [4:0] y0, wy0, y1, wy1;
    logic       vis0, we0, wd0, vis1, we1, wd1;

    int npass = 0;
    int ntotal = 0;

    always #5 clk = ~clk;

    life_cursor_ctrl #(
        .WIDTH(W), .HEIGHT(H), .WRAP(1),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .BLINK_PERIOD(BP)
    ) u0 (
        .clk(clk), .reset(reset), .enable(enable), .dir(dir),
        .mode(mode), .action(action), .cell_rd(cell_rd),
        .cur_x(x0), .cur_y(y0), .cursor_vis(vis0), .cell_we(we0),
        .cell_x(wx0), .cell_y(wy0), .cell_wdata(wd0)
    );

    life_cursor_ctrl #(
        .WIDTH(W), .HEIGHT(H), .WRAP(0),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .BLINK_PERIOD(BP)
    ) u1 (
        .clk(clk), .reset(reset), .enable(enable), .dir(dir),
        .mode(mode), .action(action), .cell_rd(cell_rd),
        .cur_x(x1), .cur_y(y1), .cursor_vis(vis1), .cell_we(we1),
        .cell_x(wx1), .cell_y(wy1), .cell_wdata(wd1)
    );

    // reference model: index 0 wraps, index 1 clamps
    int mx[2], my[2], mwx[2], mwy[2], mt[2];
    bit mwe[2], mwd[2], mvis[2];
    int hold[4];
    bit pend[4];
    bit act_prev, en_prev;

    typedef struct {
        bit en; logic [3:0] dir; logic [1:0] mode; bit act; bit rd;
        int ex; int ey; int we; int wx; int wy; int wd; int vis;
        int ex1; int we1;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(string name, int act, int exp);
        ntotal++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tchk(string name, int act, int exp);
        if (exp >= 0) chk(name, act, exp);
    endtask

    function automatic bit is_step(int h);
        return (h == 1) || (h >= 1 + RD && (h - 1 - RD) % RR == 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mx[i] = W / 2; my[i] = H / 2;
            mwx[i] = 0; mwy[i] = 0; mwe[i] = 0; mwd[i] = 0;
            mvis[i] = 0; mt[i] = 0;
        end
        for (int k = 0; k < 4; k++) begin
            hold[k] = 0; pend[k] = 0;
        end
        act_prev = 0; en_prev = 0;
    endtask

    task automatic model_edge();
        int nst, d, dx, dy, tx, ty;
        bit mv;
        nst = 0; d = 0;
        for (int k = 0; k < 4; k++)
            if (pend[k]) begin nst++; d = k; end
        dx = (d == 0) ? 1 : (d == 3) ? -1 : 0;
        dy = (d == 2) ? 1 : (d == 1) ? -1 : 0;
        for (int i = 0; i < 2; i++) begin
            mv = enable && nst == 1;
            tx = mx[i] + dx; ty = my[i] + dy;
            if (i == 0) begin
                tx = (tx + W) % W; ty = (ty + H) % H;
            end else if (tx < 0 || tx >= W || ty < 0 || ty >= H) begin
                mv = 0;
            end
            mwe[i] = 0;
            if (mv) begin
                mx[i] = tx; my[i] = ty;
                if (mode == 1 || mode == 2) begin
                    mwe[i] = 1; mwx[i] = tx; mwy[i] = ty;
                    mwd[i] = (mode == 1);
                end
            end else if (enable && action && !act_prev && mode != 0) begin
                mwe[i] = 1; mwx[i] = mx[i]; mwy[i] = my[i];
                mwd[i] = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : !cell_rd;
            end
            if (!enable) mvis[i] = 0;
            else begin
                if (!en_prev || mv) mt[i] = 0;
                else mt[i]++;
                mvis[i] = ((mt[i] / BP) % 2) == 0;
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (enable && dir[k]) hold[k]++;
            else hold[k] = 0;
            pend[k] = hold[k] > 0 && is_step(hold[k]);
        end
        act_prev = action; en_prev = enable;
    endtask

    task automatic cmp_all();
        chk("u0.cur_x", x0, mx[0]);   chk("u0.cur_y", y0, my[0]);
        chk("u0.vis", vis0, mvis[0]); chk("u0.we", we0, mwe[0]);
        chk("u0.cell_x", wx0, mwx[0]); chk("u0.cell_y", wy0, mwy[0]);
        chk("u0.wdata", wd0, mwd[0]);
        chk("u1.cur_x", x1, mx[1]);   chk("u1.cur_y", y1, my[1]);
        chk("u1.vis", vis1, mvis[1]); chk("u1.we", we1, mwe[1]);
        chk("u1.cell_x", wx1, mwx[1]); chk("u1.cell_y", wy1, mwy[1]);
        chk("u1.wdata", wd1, mwd[1]);
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        cmp_all();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        model_reset();
        cmp_all();
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic void r(bit en, logic [3:0] d, logic [1:0] m,
                              bit a, bit rd, int ex, int ey, int we,
                              int wx, int wy, int wd, int vis,
                              int ex1, int we1);
        vec_t v;
        v.en = en; v.dir = d; v.mode = m; v.act = a; v.rd = rd;
        v.ex = ex; v.ey = ey; v.we = we; v.wx = wx; v.wy = wy;
        v.wd = wd; v.vis = vis; v.ex1 = ex1; v.we1 = we1;
        tbl.push_back(v);
    endfunction

    task automatic run_tbl(string tag);
        foreach (tbl[i]) begin
            enable = tbl[i].en; dir = tbl[i].dir; mode = tbl[i].mode;
            action = tbl[i].act; cell_rd = tbl[i].rd;
            cyc();
            tchk($sformatf("%s[%0d].x", tag, i), x0, tbl[i].ex);
            tchk($sformatf("%s[%0d].y", tag, i), y0, tbl[i].ey);
            tchk($sformatf("%s[%0d].we", tag, i), we0, tbl[i].we);
            tchk($sformatf("%s[%0d].wx", tag, i), wx0, tbl[i].wx);
            tchk($sformatf("%s[%0d].wy", tag, i), wy0, tbl[i].wy);
            tchk($sformatf("%s[%0d].wd", tag, i), wd0, tbl[i].wd);
            tchk($sformatf("%s[%0d].vis", tag, i), vis0, tbl[i].vis);
            tchk($sformatf("%s[%0d].x1", tag, i), x1, tbl[i].ex1);
            tchk($sformatf("%s[%0d].we1", tag, i), we1, tbl[i].we1);
        end
        tbl.delete();
    endtask

    initial begin
        reset = 1'b0; enable = 1'b1; dir = '0; mode = '0;
        action = 1'b0; cell_rd = 1'b0;
        model_reset();
        #12;
        cmp_all();
        chk("rst.x", x0, 10);
        chk("rst.vis", vis0, 0);
        reset = 1'b1;

        // hold x-1, release, tap, walk to the left edge, wrap vs clamp
        r(1, 4'b0000, 0, 0, 0, 10, 10, 0, -1, -1, -1, 1, 10, 0);
        r(1, 4'b1000, 0, 0, 0, 10, 10, 0, -1, -1, -1, 1, 10, -1);
        r(1, 4'b1000, 0, 0, 0, 9, 10, 0, -1, -1, -1, 1, 9, -1);
        r(1, 4'b1000, 0, 0, 0, 9, -1, -1, -1, -1, -1, -1, -1, -1);
        r(1, 4'b1000, 0, 0, 0, 9, -1, -1, -1, -1, -1, -1, -1, -1);
        r(1, 4'b1000, 0, 0, 0, 9, 10, 0, -1, -1, -1, 0, -1, -1);
        r(1, 4'b1000, 0, 0, 0, 8, 10, 0, -1, -1, -1, 1, -1, -1);
        r(1, 4'b1000, 0, 0, 0, 8, -1, -1, -1, -1, -1, -1, -1, -1);
        r(1, 4'b1000, 0, 0, 0, 7, -1, -1, -1, -1, -1, -1, -1, -1);
        r(1, 4'b1000, 0, 0, 0, 7, -1, -1, -1, -1, -1, -1, -1, -1);
        r(1, 4'b1000, 0, 0, 0, 6, 10, 0, -1, -1, -1, -1, 6, -1);
        r(1, 4'b0000, 0, 0, 0, 6, -1, -1, -1, -1, -1, -1, -1, -1);
        r(1, 4'b0000, 0, 0, 0, 6, -1, -1, -1, -1, -1, -1, -1, -1);
        r(1, 4'b1000, 0, 0, 0, 6, -1, -1, -1, -1, -1, -1, -1, -1);
        r(1, 4'b0000, 0, 0, 0, 5, 10, 0, -1, -1, -1, 1, 5, -1);
        r(1, 4'b0000, 0, 0, 0, 5, -1, -1, -1, -1, -1, -1, -1, -1);
        r(1, 4'b1000, 0, 0, 0, 5, -1, -1, -1, -1, -1, -1, -1, -1);
        r(1, 4'b1000, 0, 0, 0, 4, -1, -1, -1, -1, -1, -1, -1, -1);
        r(1, 4'b1000, 0, 0, 0, 4, -1, -1, -1, -1, -1, -1, -1, -1);
        r(1, 4'b1000, 0, 0, 0, 4, -1, -1, -1, -1, -1, -1, -1, -1);
        r(1, 4'b1000, 0, 0, 0, 4, -1, -1, -1, -1, -1, -1, -1, -1);
        r(1, 4'b1000, 0, 0, 0, 3, -1, -1, -1, -1, -1, -1, -1, -1);
        r(1, 4'b1000, 0, 0, 0, 3, -1, -1, -1, -1, -1, -1, -1, -1);
        r(1, 4'b1000, 0, 0, 0, 2, -1, -1, -1, -1, -1, -1, -1, -1);
        r(1, 4'b1000, 0, 0, 0, 2, -1, -1, -1, -1, -1, -1, -1, -1);
        r(1, 4'b1000, 0, 0, 0, 1, -1, -1, -1, -1, -1, -1, -1, -1);
        r(1, 4'b1000, 0, 0, 0, 1, -1, -1, -1, -1, -1, -1, -1, -1);
        r(1, 4'b0000, 0, 0, 0, 0, 10, 0, -1, -1, -1, -1, 0, 0);
        r(1, 4'b1000, 1, 0, 0, 0, 10, 0, -1, -1, -1, -1, 0, 0);
        r(1, 4'b0000, 1, 0, 0, 19, 10, 1, 19, 10, 1, 1, 0, 0);
        r(1, 4'b0000, 1, 0, 0, 19, 10, 0, 19, 10, 1, -1, 0, 0);
        run_tbl("walk");

        do_reset();

        // paint move, toggle action, move beats action, conflicts, disable
        r(1, 4'b0000, 1, 0, 0, 10, 10, 0, 0, 0, 0, 1, 10, 0);
        r(1, 4'b0001, 1, 0, 0, 10, 10, 0, -1, -1, -1, -1, 10, 0);
        r(1, 4'b0000, 1, 0, 0, 11, 10, 1, 11, 10, 1, 1, 11, 1);
        r(1, 4'b0000, 1, 0, 0, 11, 10, 0, 11, 10, 1, -1, 11, 0);
        r(1, 4'b0000, 3, 1, 1, 11, 10, 1, 11, 10, 0, -1, 11, 1);
        r(1, 4'b0000, 3, 0, 1, 11, 10, 0, 11, 10, 0, -1, 11, 0);
        r(1, 4'b0001, 3, 0, 0, 11, 10, 0, -1, -1, -1, -1, 11, 0);
        r(1, 4'b0000, 3, 1, 0, 12, 10, 0, 11, 10, 0, 1, 12, 0);
        r(1, 4'b0000, 3, 0, 0, 12, 10, 0, -1, -1, -1, -1, 12, 0);
        r(1, 4'b1010, 1, 0, 0, 12, 10, 0, -1, -1, -1, -1, 12, 0);
        r(1, 4'b1010, 1, 0, 0, 12, 10, 0, -1, -1, -1, -1, 12, 0);
        r(1, 4'b1010, 1, 0, 0, 12, 10, 0, -1, -1, -1, -1, 12, 0);
        r(1, 4'b1010, 1, 0, 0, 12, 10, 0, -1, -1, -1, -1, 12, 0);
        r(1, 4'b0000, 1, 0, 0, 12, 10, 0, -1, -1, -1, -1, 12, 0);
        r(0, 4'b0001, 1, 1, 0, 12, 10, 0, -1, -1, -1, 0, 12, 0);
        r(0, 4'b0000, 1, 1, 0, 12, 10, 0, -1, -1, -1, 0, 12, 0);
        r(0, 4'b0001, 1, 1, 0, 12, 10, 0, -1, -1, -1, 0, 12, 0);
        r(0, 4'b0000, 1, 1, 0, 12, 10, 0, -1, -1, -1, 0, 12, 0);
        r(0, 4'b1000, 1, 1, 0, 12, 10, 0, -1, -1, -1, 0, 12, 0);
        r(1, 4'b0000, 1, 1, 0, 12, 10, 0, -1, -1, -1, 1, 12, 0);
        r(1, 4'b0000, 1, 1, 0, 12, 10, 0, -1, -1, -1, 1, 12, 0);
        r(1, 4'b0000, 1, 0, 0, 12, 10, 0, -1, -1, -1, -1, 12, 0);
        r(1, 4'b0000, 1, 1, 0, 12, 10, 1, 12, 10, 1, -1, 12, 1);
        run_tbl("edit");

        // random bursts of held buttons against the model
        for (int s = 0; s < 80; s++) begin
            int pick, len;
            pick = $urandom_range(0, 9);
            if (pick < 4) dir = '0;
            else if (pick < 9) dir = 4'(1 << $urandom_range(0, 3));
            else dir = 4'($urandom_range(0, 15));
            len = $urandom_range(1, 12);
            for (int c = 0; c < len; c++) begin
                enable = ($urandom_range(0, 19) != 0);
                if (c == 0 || $urandom_range(0, 4) == 0)
                    mode = 2'($urandom_range(0, 3));
                action = ($urandom_range(0, 3) == 0);
                cell_rd = 1'($urandom_range(0, 1));
                cyc();
            end
        end

        // reset in the middle of a hold; the held key is a new press
        enable = 1'b1; mode = 2'b00; action = 1'b0; dir = 4'b0001;
        cyc(); cyc(); cyc();
        do_reset();
        chk("midrst.x", x0, 10);
        chk("midrst.we", we0, 0);
        cyc();
        chk("newpress.x0", x0, 10);
        cyc();
        chk("newpress.x1", x0, 11);
        chk("newpress.y", y0, 10);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
